// File: rtl/uart_tx_arb_if.sv
// Requester, UART and status signals of the packet arbiter in front of a UART transmitter.
interface uart_tx_arb_if;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic        transmit;
    logic [7:0]  data_tx;
    logic        busy_tx;
    logic [1:0]  grant_id;
    logic        active;
    logic        err;

    modport master (
        output req, data, last, busy_tx,
        input  ack, transmit, data_tx, grant_id, active, err
    );

    modport slave (
        input  req, data, last, busy_tx,
        output ack, transmit, data_tx, grant_id, active, err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter: sends a header byte followed by the owner's data bytes to a UART,
// pacing each byte on the transmitter's busy handshake and guarding every wait with a watchdog.
module uart_tx_arb #(
    parameter int          NREQ     = 4,
    parameter logic [7:0]  HDR_BASE = 8'hA0,
    parameter logic [15:0] TMO      = 16'd8191
) (
    input  logic         clk,
    input  logic         nRst,
    uart_tx_arb_if.slave bus
);

    // state | meaning: IDLE arbitrate | HDR load header | DATA await owner byte | WAIT_HI/WAIT_LO follow busy_tx
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t      state, state_n;
    logic [1:0]  ptr, ptr_n;
    logic [1:0]  grant_n;
    logic [1:0]  pick;
    logic        found;
    logic        hdr_flag, hdr_flag_n;
    logic        last_q, last_q_n;
    logic [15:0] cnt, cnt_n;
    logic        waiting;
    logic        timeout;
    logic [7:0]  data_tx_n;
    logic        transmit_n;
    logic [3:0]  ack_n;
    logic        err_n;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        grant_n    = bus.grant_id;
        hdr_flag_n = hdr_flag;
        last_q_n   = last_q;
        data_tx_n  = bus.data_tx;
        transmit_n = 1'b0;
        ack_n      = 4'b0000;
        err_n      = bus.err;
        found      = 1'b0;
        pick       = ptr;

        // Descending scan so the requester closest to ptr wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[ptr + 2'(i)]) begin
                found = 1'b1;
                pick  = ptr + 2'(i);
            end
        end

        waiting = (state == DATA) || (state == WAIT_HI) || (state == WAIT_LO);
        timeout = waiting && (cnt == TMO);

        if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
            ptr_n   = bus.grant_id + 2'd1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found && !bus.busy_tx) begin
                        grant_n = pick;
                        state_n = HDR;
                    end
                end
                HDR: begin
                    data_tx_n  = HDR_BASE | {6'd0, bus.grant_id};
                    transmit_n = 1'b1;
                    hdr_flag_n = 1'b1;
                    state_n    = WAIT_HI;
                end
                DATA: begin
                    if (bus.req[bus.grant_id]) begin
                        data_tx_n             = bus.data[{bus.grant_id, 3'b000} +: 8];
                        last_q_n              = bus.last[bus.grant_id];
                        transmit_n            = 1'b1;
                        ack_n[bus.grant_id]   = 1'b1;
                        hdr_flag_n            = 1'b0;
                        state_n               = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.busy_tx) begin
                        state_n = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!bus.busy_tx) begin
                        if (hdr_flag || !last_q) begin
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                            ptr_n   = bus.grant_id + 2'd1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (state_n != state) begin
            cnt_n = 16'd0;
        end else if (waiting) begin
            cnt_n = cnt + 16'd1;
        end else begin
            cnt_n = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            hdr_flag     <= 1'b0;
            last_q       <= 1'b0;
            cnt          <= 16'd0;
            bus.ack      <= 4'b0000;
            bus.transmit <= 1'b0;
            bus.data_tx  <= 8'h00;
            bus.grant_id <= 2'd0;
            bus.active   <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            hdr_flag     <= hdr_flag_n;
            last_q       <= last_q_n;
            cnt          <= cnt_n;
            bus.ack      <= ack_n;
            bus.transmit <= transmit_n;
            bus.data_tx  <= data_tx_n;
            bus.grant_id <= grant_n;
            bus.active   <= (state_n != IDLE);
            bus.err      <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester/UART behavioural models with a packet-level reference stream.
module tb_uart_tx_arb;
    localparam logic [7:0] HDR_BASE = 8'hA0;
    localparam int         TMO      = 8191;

    logic clk  = 1'b0;
    logic nRst = 1'b0;

    uart_tx_arb_if bus ();

    uart_tx_arb #(.NREQ(4), .HDR_BASE(HDR_BASE), .TMO(16'(TMO))) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] pbyte [4][32];
    logic       plast [4][32];
    int         pcnt [4];
    int         pos [4];
    int         stall_cnt [4];
    int         stall_min, stall_max, dly_min, dly_max, len_min, len_max;
    bit         uart_dead, force_busy;
    int         u_dly, u_len;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         tx_cnt, ack_cnt, prot_viol;
    bit         prev_tx, prev_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        if (force_busy) bus.busy_tx = 1'b1;
        else if (u_dly > 0) begin bus.busy_tx = 1'b0; u_dly--; end
        else if (u_len > 0) begin bus.busy_tx = 1'b1; u_len--; end
        else bus.busy_tx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (stall_cnt[i] > 0) begin
                bus.req[i] = 1'b0;
                stall_cnt[i]--;
            end else if (pos[i] < pcnt[i]) begin
                bus.req[i]        = 1'b1;
                bus.data[8*i +: 8] = pbyte[i][pos[i]];
                bus.last[i]       = plast[i][pos[i]];
            end else begin
                bus.req[i]  = 1'b0;
                bus.last[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.transmit === 1'b1) begin
            rx_q.push_back(bus.data_tx);
            tx_cnt++;
        end
        if (prev_tx && bus.transmit === 1'b1) prot_viol++;
        if (prev_ack && bus.ack != 4'b0000) prot_viol++;
        if ($countones(bus.ack) > 1) prot_viol++;
        for (int i = 0; i < 4; i++) begin
            if (bus.ack[i] === 1'b1) begin
                ack_cnt++;
                if (pos[i] >= pcnt[i] || bus.transmit !== 1'b1 || bus.data_tx !== pbyte[i][pos[i]]
                    || bus.grant_id !== 2'(i)) prot_viol++;
                if (pos[i] < pcnt[i]) begin
                    if (!plast[i][pos[i]]) stall_cnt[i] = int'($urandom_range(stall_max, stall_min));
                    pos[i]++;
                end
            end
        end
        prev_tx  = (bus.transmit === 1'b1);
        prev_ack = (bus.ack != 4'b0000);
        if (bus.transmit === 1'b1 && !uart_dead) begin
            u_dly = int'($urandom_range(dly_max, dly_min));
            u_len = int'($urandom_range(len_max, len_min));
        end
        drive_inputs();
    endtask

    task automatic init_models();
        for (int i = 0; i < 4; i++) begin
            pcnt[i] = 0; pos[i] = 0; stall_cnt[i] = 0;
        end
        u_dly = 0; u_len = 0; uart_dead = 0; force_busy = 0;
        rx_q.delete(); exp_q.delete();
        tx_cnt = 0; ack_cnt = 0; prot_viol = 0; prev_tx = 0; prev_ack = 0;
        stall_min = 0; stall_max = 0; dly_min = 0; dly_max = 0; len_min = 1; len_max = 1;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        init_models();
        drive_inputs();
        tick();
        tick();
        nRst = 1'b1;
    endtask

    task automatic add_pkt(input int i, input int len);
        for (int b = 0; b < len; b++) begin
            pbyte[i][pcnt[i]] = 8'($urandom);
            plast[i][pcnt[i]] = (b == len - 1);
            pcnt[i]++;
        end
    endtask

    function automatic int sum_bytes();
        int s = 0;
        for (int i = 0; i < 4; i++) s += pcnt[i];
        return s;
    endfunction

    // Whole-packet round robin: owner is the first pending requester from ptr, then ptr = owner+1.
    task automatic build_expected();
        int p [4];
        int ptr_m = 0;
        int id = 0;
        bit found;
        bit lst;
        for (int i = 0; i < 4; i++) p[i] = 0;
        do begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && p[(ptr_m + k) % 4] < pcnt[(ptr_m + k) % 4]) begin
                    found = 1;
                    id    = (ptr_m + k) % 4;
                end
            end
            if (found) begin
                exp_q.push_back(HDR_BASE | 8'(id));
                do begin
                    exp_q.push_back(pbyte[id][p[id]]);
                    lst = plast[id][p[id]];
                    p[id]++;
                end while (!lst);
                ptr_m = (id + 1) % 4;
            end
        end while (found);
    endtask

    task automatic run_done(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(rx_q.size() >= exp_q.size() && bus.active === 1'b0
                               && u_len == 0 && u_dly == 0)) begin
            tick();
            n++;
        end
        check({tag, "_done"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic compare_stream(input string tag, input int exp_acks);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[k]), 32'(exp_q[k]));
        check({tag, "_acks"}, 32'(ack_cnt), 32'(exp_acks));
        check({tag, "_protocol"}, 32'(prot_viol), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, t0, t1, nb;
        bus.req = 4'b0; bus.data = 32'b0; bus.last = 4'b0; bus.busy_tx = 1'b0;
        init_models();
        do_reset();
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_transmit", 32'(bus.transmit), 32'd0);
        check("rst_data_tx", 32'(bus.data_tx), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        // Single-byte packet from requester 2, UART busy 10 cycles per byte.
        len_min = 10; len_max = 10;
        pbyte[2][0] = 8'h55; plast[2][0] = 1'b1; pcnt[2] = 1;
        build_expected();
        drive_inputs();
        t0 = cyc; n = 0;
        while (bus.transmit !== 1'b1 && n < 100) begin tick(); n++; end
        check("s1_hdr_latency", 32'(cyc - t0), 32'd2);
        n = 0;
        while (ack_cnt < 1 && n < 200) begin tick(); n++; end
        check("s1_ack_bit", 32'(bus.ack), 32'h4);
        check("s1_ack_with_tx", 32'(bus.transmit), 32'd1);
        t1 = cyc; n = 0;
        while (bus.active === 1'b1 && n < 200) begin tick(); n++; end
        check("s1_release", 32'(cyc - t1), 32'd11);
        run_done("s1", 100);
        compare_stream("s1", 1);

        // All four requesting, two-byte packets, requester 0 has a second packet.
        do_reset();
        dly_min = 0; dly_max = 2; len_min = 1; len_max = 4; stall_min = 0; stall_max = 2;
        add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2); add_pkt(3, 2);
        build_expected();
        drive_inputs();
        run_done("s2", 2000);
        compare_stream("s2", 10);

        // Requester 1 stalls 20 cycles mid-packet while requester 3 waits.
        do_reset();
        len_min = 3; len_max = 3; stall_min = 20; stall_max = 20;
        add_pkt(1, 2); add_pkt(3, 1);
        build_expected();
        drive_inputs();
        n = 0;
        while (ack_cnt < 1 && n < 200) begin tick(); n++; end
        t1 = cyc;
        repeat (10) tick();
        check("s3_stall_active", 32'(bus.active), 32'd1);
        check("s3_stall_grant", 32'(bus.grant_id), 32'd1);
        check("s3_stall_no_tx", 32'(tx_cnt), 32'd2);
        n = 0;
        while (tx_cnt < 3 && n < 200) begin tick(); n++; end
        check("s3_stall_gap", 32'(cyc - t1), 32'd21);
        run_done("s3", 300);
        compare_stream("s3", 3);

        // UART never goes busy after the header: watchdog fires.
        do_reset();
        uart_dead = 1;
        add_pkt(2, 1); add_pkt(3, 1);
        drive_inputs();
        n = 0;
        while (tx_cnt < 1 && n < 100) begin tick(); n++; end
        check("s4_hdr", 32'(bus.data_tx), 32'(HDR_BASE | 8'h02));
        t0 = cyc;
        while (cyc < t0 + TMO) tick();
        check("s4_err_before", 32'(bus.err), 32'd0);
        tick();
        check("s4_err_set", 32'(bus.err), 32'd1);
        check("s4_inactive", 32'(bus.active), 32'd0);
        check("s4_no_ack", 32'(ack_cnt), 32'd0);
        uart_dead = 0; len_min = 2; len_max = 2;
        exp_q.push_back(HDR_BASE | 8'h02);
        exp_q.push_back(HDR_BASE | 8'h03);
        exp_q.push_back(pbyte[3][0]);
        exp_q.push_back(HDR_BASE | 8'h02);
        exp_q.push_back(pbyte[2][0]);
        run_done("s4", 500);
        compare_stream("s4", 2);
        check("s4_err_sticky", 32'(bus.err), 32'd1);

        // Reset while waiting for busy to fall after byte 2.
        do_reset();
        check("s5_err_cleared", 32'(bus.err), 32'd0);
        len_min = 10; len_max = 10;
        add_pkt(0, 3);
        drive_inputs();
        n = 0;
        while (ack_cnt < 2 && n < 300) begin tick(); n++; end
        tick();
        tick();
        check("s5_pre_active", 32'(bus.active), 32'd1);
        nRst = 1'b0;
        tick();
        check("s5_ack", 32'(bus.ack), 32'd0);
        check("s5_transmit", 32'(bus.transmit), 32'd0);
        check("s5_data_tx", 32'(bus.data_tx), 32'd0);
        check("s5_grant", 32'(bus.grant_id), 32'd0);
        check("s5_active", 32'(bus.active), 32'd0);
        check("s5_err", 32'(bus.err), 32'd0);
        init_models();
        add_pkt(3, 1);
        build_expected();
        drive_inputs();
        nRst = 1'b1;
        run_done("s5", 200);
        compare_stream("s5", 1);

        // UART busy while idle holds off the grant.
        do_reset();
        force_busy = 1;
        add_pkt(0, 1);
        build_expected();
        drive_inputs();
        repeat (15) tick();
        check("s6_no_tx", 32'(tx_cnt), 32'd0);
        check("s6_idle", 32'(bus.active), 32'd0);
        force_busy = 0;
        bus.busy_tx = 1'b0;
        t0 = cyc; n = 0;
        while (bus.transmit !== 1'b1 && n < 50) begin tick(); n++; end
        check("s6_latency", 32'(cyc - t0), 32'd2);
        check("s6_hdr", 32'(bus.data_tx), 32'(HDR_BASE));
        run_done("s6", 100);
        compare_stream("s6", 1);

        // Randomized packet mixes.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            dly_min = 0; dly_max = 2; len_min = 1; len_max = 6; stall_min = 0; stall_max = 4;
            for (int i = 0; i < 4; i++) begin
                nb = int'($urandom_range(3, 0));
                for (int p = 0; p < nb; p++) add_pkt(i, int'($urandom_range(4, 1)));
            end
            build_expected();
            drive_inputs();
            run_done($sformatf("rnd%0d", r), 5000);
            compare_stream($sformatf("rnd%0d", r), sum_bytes());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4; ids 0..3).
REQ-002 Parameter: HDR_BASE, 8'hA0, header byte base; header = HDR_BASE | id.
REQ-003 Parameter: TMO, 16'd8191, watchdog limit in clk cycles per wait phase.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 nRst  in  1  reset, synchronous, active-low.
REQ-006 req  in  4  per-requester byte valid; held until ack.
REQ-007 data  in  32  packed bytes; requester i on data[8i+7:8i].
REQ-008 last  in  4  per-requester end-of-packet flag, qualified by req.
REQ-009 ack  out  4  one-cycle pulse: byte of requester i consumed.
REQ-010 transmit  out  1  one-cycle start pulse to the UART transmitter.
REQ-011 data_tx  out  8  byte to the UART, stable from transmit until the next load.
REQ-012 busy_tx  in  1  UART transmitter busy.
REQ-013 grant_id  out  2  id of the current packet owner.
REQ-014 active  out  1  high while a packet is owned (any state except IDLE).
REQ-015 err  out  1  sticky watchdog error flag.

Function
REQ-016 States SHALL be IDLE, HDR, DATA, WAIT_HI and WAIT_LO; all outputs registered.
REQ-017 IDLE: when |req and busy_tx=0, grant the first requester with req=1, scanning ptr, ptr+1, ... modulo 4; latch grant_id; go to HDR.
REQ-018 HDR: data_tx <= HDR_BASE | grant_id, transmit <= 1 for exactly one cycle, set hdr_flag; go to WAIT_HI.
REQ-019 WAIT_HI: on busy_tx=1 go to WAIT_LO.
REQ-020 WAIT_LO: on busy_tx=0, go to DATA if hdr_flag=1 or the latched last=0; otherwise go to IDLE with ptr <= grant_id+1 (mod 4).
REQ-021 DATA, req[grant_id]=1: latch the byte into data_tx and last into last_q; pulse transmit and ack[grant_id] in the same cycle; clear hdr_flag; go to WAIT_HI.
REQ-022 DATA, req[grant_id]=0: stall in DATA; no pulses.
REQ-023 The request and data of requesters other than grant_id SHALL be ignored until the packet ends; grant SHALL NOT change mid-packet.
REQ-024 The 16-bit watchdog counter SHALL clear on every state entry and increment each cycle in DATA, WAIT_HI and WAIT_LO.
REQ-025 When the counter reaches TMO, the block SHALL set err=1, go to IDLE, set ptr <= grant_id+1 and leave ack unpulsed.
REQ-026 err SHALL clear only on reset.
REQ-027 At most one ack bit SHALL be high in any cycle; ack and transmit SHALL never be high two consecutive cycles.
REQ-028 A single-byte packet (last=1 on the first byte) SHALL produce exactly header then byte, then release.
REQ-029 A request that rises in the same cycle the grant releases SHALL be arbitrated in the next IDLE cycle using the updated ptr.

Reset
REQ-030 With nRst=0 at a rising edge, the block SHALL reset: state IDLE, ptr 0, hdr_flag 0, counter 0, last_q 0.
REQ-031 Output reset values: ack 0, transmit 0, data_tx 8'h00, grant_id 0, active 0, err 0.
REQ-032 Reset mid-packet SHALL abort immediately with no further ack or transmit; the next grant starts with ptr 0.

Verification
REQ-033 Scenario 1: req[2]=1, data byte 8'h55, last=1; UART model holds busy 10 cycles after each transmit -> data_tx sequence A2, 55; one ack[2] pulse, issued on the transmit cycle of 55; active drops after the second busy fall.
REQ-034 Scenario 2: req=4'b1111, each packet 2 bytes -> grant order 0, 1, 2, 3, then 0; headers A0, A1, A2, A3; no interleaving of bytes between packets.
REQ-035 Scenario 3: requester 1 stalls 20 cycles between bytes 1 and 2 -> block waits in DATA with no transmit; requester 3 request is not granted until requester 1 sends last.
REQ-036 Scenario 4: UART model never raises busy after the header -> err=1 at TMO+1 cycles after entering WAIT_HI; active=0; next grant goes to grant_id+1.
REQ-037 Scenario 5: nRst pulsed low while in WAIT_LO of byte 2 -> all outputs at reset values next cycle; subsequent req[3] gets header A3.
REQ-038 Scenario 6: busy_tx=1 held in IDLE with req=4'b0001 -> no grant until busy_tx=0, then header A0.
